// File: rtl/bcd_serial_adder.sv
// Packed-BCD serial adder/subtractor: one decimal digit per clock, LSD first.
// Subtraction uses nine's complement of b plus inverted borrow (ten's complement).
module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  input  logic                  op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  error
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     a_r, b_r, sum_r, b_cmp;
  logic             c_r, cout_r, err_r;
  logic [IDX_W-1:0] idx_r;
  logic             accept, bad_digit, last_digit, c_nxt;
  logic [3:0]       a_d, b_d, digit;
  logic [4:0]       s;

  // Operand screening and nine's complement of b, per digit
  always_comb begin
    bad_digit = 1'b0;
    b_cmp     = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      b_cmp[4*i +: 4] = 4'd9 - b[4*i +: 4];
    end
  end

  // Single-digit decimal add with +6 correction
  always_comb begin
    a_d = '0;
    b_d = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_r == IDX_W'(i)) begin
        a_d = a_r[4*i +: 4];
        b_d = b_r[4*i +: 4];
      end
    end
    s = {1'b0, a_d} + {1'b0, b_d} + {4'b0, c_r};
    if (s > 5'd9) begin
      digit = s[3:0] + 4'd6;
      c_nxt = 1'b1;
    end else begin
      digit = s[3:0];
      c_nxt = 1'b0;
    end
  end

  assign last_digit = (idx_r == IDX_W'(DIGITS - 1));
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad_digit ? DONE : CALC;
      CALC:    if (last_digit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state == IDLE);
    out_valid = (state == DONE);
    sum       = sum_r;
    cout      = cout_r;
    error     = err_r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      c_r    <= 1'b0;
      idx_r  <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_r    <= a;
          b_r    <= op ? b_cmp : b;
          c_r    <= cin ^ op;
          idx_r  <= '0;
          sum_r  <= '0;
          cout_r <= 1'b0;
          err_r  <= bad_digit;
        end
        CALC: begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) sum_r[4*i +: 4] <= digit;
          end
          idx_r <= idx_r + IDX_W'(1);
          c_r   <= c_nxt;
          if (last_digit) cout_r <= c_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
